mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Parametrised load/store unit between the datapath (ALUResult as address, WriteData as store data) and a data memory with a ready handshake.
//  Supports byte, halfword and word accesses with zero- or sign-extension on loads.
//  Generates lane byte-enables and replicated store data, and stalls the core while busy.
//  Reports misaligned or illegal accesses and memory timeouts instead of hanging.
// PARAMETERS
//  DW       32   data width in bits; power of two, >= 32
//  AW       32   address width in bits
//  TIMEOUT  255  max cycles in REQ waiting for mem_ready before abort; >= 1
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        asynchronous, active-low reset
//  start         in   1        request an access; sampled only in IDLE
//  is_load       in   1        1 = load, 0 = store
//  size          in   2        00 byte, 01 half, 10 word, 11 illegal
//  sign_ext      in   1        loads only: 1 = sign-extend, 0 = zero-extend
//  addr          in   AW       byte address
//  store_data    in   DW       store value; low bits used for byte/half
//  busy          out  1        high from the cycle after start until done, inclusive
//  done          out  1        one-cycle completion pulse
//  load_data     out  DW       extended load result; valid while done, held until next start
//  misalign_err  out  1        valid with done: misaligned or illegal size
//  timeout_err   out  1        valid with done: memory never answered
//  mem_req       out  1        memory request
//  mem_we        out  1        memory write enable (with mem_req)
//  mem_addr      out  AW       addr with low log2(DW/8) bits cleared
//  mem_be        out  DW/8     byte enables
//  mem_wdata     out  DW       lane-replicated store data
//  mem_rdata     in   DW       read data; valid when mem_ready
//  mem_ready     in   1        memory completes the request this cycle
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE. busy, done, mem_req, mem_we, misalign_err and timeout_err = 0.
//   load_data, mem_addr, mem_be and mem_wdata = 0. Timeout counter = 0.
//  FSM IDLE -> REQ | DONE; REQ -> DONE; DONE -> IDLE.
//  IDLE: on start=1, register is_load, size, sign_ext, addr and store_data.
//   If aligned and legal: go to REQ. Otherwise go to DONE with misalign_err=1; no memory request is issued.
//  Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=0. size=11 is illegal.
//  REQ: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are registered and stable for all of REQ.
//   Lane offset off = addr[log2(DW/8)-1:0].
//   mem_be: byte = 1<<off; half = 2'b11<<off; word = 4'hF<<off.
//   mem_wdata: byte = store_data[7:0] replicated; half = store_data[15:0] replicated; word = store_data[31:0] replicated.
//   mem_ready=1 while in REQ: capture mem_rdata, go to DONE.
//    Load extraction: take lane bytes starting at off, then zero/sign-extend to DW.
//   Counter increments each REQ cycle without ready. When it reaches TIMEOUT: go to DONE with timeout_err=1, load_data=0.
//  DONE: done=1, busy=1, mem_req=0 for exactly one cycle, then IDLE.
//   Both error flags are cleared on the next accepted start.
//  Latency: start in cycle 0 -> mem_req in cycle 1 -> with ready in cycle N, done in cycle N+1. Misaligned: done in cycle 1.
//  start while busy is ignored; it is not queued.
//  mem_ready outside REQ is ignored.
//  Stores leave load_data unchanged.
//  Reset asserted mid-access: mem_req drops immediately, and the pending access is lost.
// TESTING
//  1. Word at 0x100 = 0x8899AABB; LDRB addr 0x102, unsigned, ready in cycle 1 -> done in cycle 2, load_data=0x00000099.
//  2. Same, sign_ext=1 -> 0xFFFFFF99. LDRH addr 0x102 signed -> 0xFFFF8899. LDR addr 0x100 -> 0x8899AABB.
//  3. STRB addr 0x103, store_data 0x12345678 -> mem_addr 0x100, mem_be 4'b1000, mem_wdata 0x78787878, mem_we=1.
//     STRH addr 0x102 -> mem_be 4'b1100, mem_wdata 0x56785678.
//  4. LDRH addr 0x101, or size=11 -> done in cycle 1, misalign_err=1, mem_req never asserted.
//  5. TIMEOUT=4, mem_ready held 0 -> mem_req high for 4 cycles, then done with timeout_err=1, load_data=0.
//     Next legal access clears timeout_err.
//  6. Assert reset during REQ -> mem_req, busy and done go to 0 without a clock edge. After release, a new start works normally.
//     Also: start pulsed while busy -> ignored, no second mem_req.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store unit with a ready handshake to
// data memory. It checks alignment, drives lane byte-enables and
// lane-replicated store data, extracts and extends load data, and aborts
// with an error flag when the memory does not answer in time.
module mem_access_unit #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_load,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   store_data,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   load_data,
  output logic            misalign_err,
  output logic            timeout_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_nx;
  logic            ld_q, sext_q;
  logic [1:0]      size_q;
  logic [OW-1:0]   off_q;
  logic [CW-1:0]   cnt;

  logic [OW-1:0]   off;
  logic            ok;
  logic [NB-1:0]   be_c;
  logic [DW-1:0]   wdata_c;
  logic [DW-1:0]   sh;
  logic [DW-1:0]   ext;
  logic            tmo;

  assign off = addr[OW-1:0];
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  // Legality and alignment of the incoming request
  always_comb begin
    ok = 1'b0;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr[0];
      2'b10:   ok = (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
  end

  // Lane byte-enables and replicated write data for the incoming request
  always_comb begin
    be_c    = '0;
    wdata_c = '0;
    case (size)
      2'b00: begin
        be_c    = NB'(1) << off;
        wdata_c = {NB{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = NB'(3) << off;
        wdata_c = {(NB/2){store_data[15:0]}};
      end
      default: begin
        be_c    = NB'(4'hF) << off;
        wdata_c = {(NB/4){store_data[31:0]}};
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then extend
  assign sh = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = '0;
    case (size_q)
      2'b00:   ext = sext_q ? DW'($signed(sh[7:0]))  : DW'(sh[7:0]);
      2'b01:   ext = sext_q ? DW'($signed(sh[15:0])) : DW'(sh[15:0]);
      default: ext = sext_q ? DW'($signed(sh[31:0])) : DW'(sh[31:0]);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; handshake outputs decode straight from state so an
  // asynchronous reset drops them without waiting for a clock edge
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_req  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = ok ? REQ : DONE;
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready || tmo) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, timeout counting, result and error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_q         <= 1'b0;
      sext_q       <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= '0;
      cnt          <= '0;
      load_data    <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ld_q         <= is_load;
          sext_q       <= sign_ext;
          size_q       <= size;
          off_q        <= off;
          cnt          <= '0;
          misalign_err <= ~ok;
          timeout_err  <= 1'b0;
          // memory-side outputs only change for requests that will be issued
          if (ok) begin
            mem_we    <= ~is_load;
            mem_addr  <= {addr[AW-1:OW], OW'(0)};
            mem_be    <= be_c;
            mem_wdata <= wdata_c;
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (ld_q) load_data <= ext;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            load_data   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
